// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops FIFO words and shifts them out as UART-style frames
module fifo_word_serializer #(
  parameter int fifo_width = 16,
  parameter int BIT_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [fifo_width-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  ser_out,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int DIV_W = $clog2(BIT_PERIOD) + 1;
  localparam int BIT_W = $clog2(fifo_width) + 1;

  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [fifo_width-1:0] shift_q, shift_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  r_en_q, r_en_d;
  logic                  ser_q, ser_d;
  logic                  bit_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      r_en_q  <= 1'b0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      r_en_q  <= r_en_d;
      ser_q   <= ser_d;
    end
  end

  assign bit_done = (div_q == DIV_W'(BIT_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    r_en_d  = 1'b0;
    // Line level follows the state one cycle later, keeping ser_out a pure flop output.
    ser_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = POP;
          r_en_d  = 1'b1;
        end
      end
      POP: state_d = WAIT;
      WAIT: begin
        shift_d = fifo_data;
        div_d   = '0;
        state_d = START;
      end
      START: begin
        ser_d = 1'b0;
        if (bit_done) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        ser_d = shift_q[0];
        if (bit_done) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(fifo_width - 1)) state_d = STOP;
          else                                  bit_d   = bit_q + BIT_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          div_d = '0;
          cnt_d = cnt_q + 16'd1;
          if (enable && !fifo_empty) begin
            state_d = POP;
            r_en_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_r_en  = r_en_q;
  assign ser_out    = ser_q;
  assign busy       = (state_q != IDLE);
  assign words_sent = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - directed bench for fifo_word_serializer
module tb_fifo_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable4 = 1'b0, enable1 = 1'b0;
  logic r_en4, ser4, busy4, r_en1, ser1, busy1;
  logic [15:0] ws4, ws1;
  int ncmp = 0, nfail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous FIFOs, one per DUT
  logic [15:0] mem4 [0:255];
  logic [15:0] mem1 [0:255];
  logic [7:0]  wp4 = 0, rp4 = 0, wp1 = 0, rp1 = 0;
  logic [15:0] fdata4 = '0, fdata1 = '0;
  logic        empty4, empty1;
  int          rc4 = 0, rc1 = 0, bad4 = 0, bad1 = 0;
  assign empty4 = (wp4 == rp4);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (r_en4) rc4 <= rc4 + 1;
    if (r_en4 && empty4) bad4 <= bad4 + 1;
    if (r_en4 && !empty4) begin
      fdata4 <= mem4[rp4];
      rp4    <= rp4 + 8'd1;
    end
    if (r_en1) rc1 <= rc1 + 1;
    if (r_en1 && empty1) bad1 <= bad1 + 1;
    if (r_en1 && !empty1) begin
      fdata1 <= mem1[rp1];
      rp1    <= rp1 + 8'd1;
    end
  end

  fifo_word_serializer #(.fifo_width(16), .BIT_PERIOD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .fifo_empty(empty4), .fifo_data(fdata4),
    .fifo_r_en(r_en4), .ser_out(ser4), .busy(busy4), .words_sent(ws4));

  fifo_word_serializer #(.fifo_width(16), .BIT_PERIOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .fifo_empty(empty1), .fifo_data(fdata1),
    .fifo_r_en(r_en1), .ser_out(ser1), .busy(busy1), .words_sent(ws1));

  task automatic push4(input logic [15:0] d);
    mem4[wp4] = d;
    wp4 = wp4 + 8'd1;
  endtask

  task automatic push1(input logic [15:0] d);
    mem1[wp1] = d;
    wp1 = wp1 + 8'd1;
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? ser1 : ser4;
  endfunction

  // Decodes one frame sampled on falling edges; t0 is the cycle the start bit was first seen.
  task automatic recv(input int sel, output logic [15:0] w, output int t0);
    int bp = (sel == 1) ? 1 : 4;
    int n = 0;
    bit bad = 0;
    logic v;
    w  = 'x;
    t0 = -1;
    @(negedge clk);
    while (line(sel) !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ncmp++;
    if (n >= 400) begin
      nfail++;
      $display("FAIL recv_timeout dut_bp=%0d: no start bit seen within 400 cycles", bp);
      return;
    end
    t0 = cyc;
    for (int i = 1; i < bp; i++) begin
      @(negedge clk);
      if (line(sel) !== 1'b0) bad = 1;
    end
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < bp; j++) begin
        @(negedge clk);
        v = line(sel);
        if (j == 0) w[b] = v;
        else if (v !== w[b]) bad = 1;
      end
    end
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      if (line(sel) !== 1'b1) bad = 1;
    end
    ncmp++;
    if (bad) begin
      nfail++;
      $display("FAIL frame_shape dut_bp=%0d: unstable bit, low stop or short start (word %h)", bp, w);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (ser4 !== 1'b1)   begin nfail++; $display("FAIL reset_ser got %b want 1", ser4); end
    ncmp++; if (r_en4 !== 1'b0)  begin nfail++; $display("FAIL reset_r_en got %b want 0", r_en4); end
    ncmp++; if (busy4 !== 1'b0)  begin nfail++; $display("FAIL reset_busy got %b want 0", busy4); end
    ncmp++; if (ws4 !== 16'd0)   begin nfail++; $display("FAIL reset_words got %h want 0000", ws4); end
    ncmp++; if ($isunknown({ser1, r_en1, busy1, ws1}) || ser1 !== 1'b1 || ws1 !== 16'd0) begin
      nfail++; $display("FAIL reset_bp1 got ser=%b words=%h want 1/0000", ser1, ws1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [15:0] w;
    int t0, pc, rc0;
    enable4 = 1'b1;
    @(negedge clk);
    rc0 = rc4;
    pc  = cyc;
    push4(16'hA5C3);
    recv(0, w, t0);
    ncmp++; if (w !== 16'hA5C3) begin nfail++; $display("FAIL single_word got %h want a5c3", w); end
    ncmp++; if (t0 - pc !== 4)  begin nfail++; $display("FAIL single_latency got %0d want 4", t0 - pc); end
    repeat (3) @(negedge clk);
    ncmp++; if (ws4 !== 16'd1)  begin nfail++; $display("FAIL single_words got %0d want 1", ws4); end
    ncmp++; if (busy4 !== 1'b0) begin nfail++; $display("FAIL single_busy got %b want 0", busy4); end
    ncmp++; if (rc4 - rc0 !== 1) begin nfail++; $display("FAIL single_pulses got %0d want 1", rc4 - rc0); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w;
    int t0, tp, rc0;
    rc0 = rc4;
    for (int i = 0; i < 8; i++) push4(16'(i));
    for (int i = 0; i < 8; i++) begin
      recv(0, w, t0);
      ncmp++; if (w !== 16'(i)) begin nfail++; $display("FAIL burst_word%0d got %h want %h", i, w, 16'(i)); end
      if (i > 0) begin
        ncmp++; if (t0 - tp !== 74) begin nfail++; $display("FAIL burst_gap%0d got %0d want 74", i, t0 - tp); end
      end
      tp = t0;
    end
    repeat (20) @(negedge clk);
    ncmp++; if (ws4 !== 16'd9)   begin nfail++; $display("FAIL burst_words got %0d want 9", ws4); end
    ncmp++; if (rc4 - rc0 !== 8) begin nfail++; $display("FAIL burst_pulses got %0d want 8", rc4 - rc0); end
    ncmp++; if (bad4 !== 0)      begin nfail++; $display("FAIL burst_empty_pop got %0d want 0", bad4); end
  endtask

  task automatic test_enable;
    logic [15:0] w;
    int t0, rc0;
    bit bad = 0;
    enable4 = 1'b0;
    @(negedge clk);
    rc0 = rc4;
    push4(16'h0010); push4(16'h0011); push4(16'h0012);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ser4 !== 1'b1 || r_en4 !== 1'b0) bad = 1;
    end
    ncmp++; if (bad || rc4 != rc0) begin nfail++; $display("FAIL disabled_idle got pulses=%0d want 0", rc4 - rc0); end
    enable4 = 1'b1;
    fork
      recv(0, w, t0);
      begin
        repeat (12) @(negedge clk);
        enable4 = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    ncmp++; if (w !== 16'h0010)   begin nfail++; $display("FAIL drop_word got %h want 0010", w); end
    ncmp++; if (rc4 - rc0 !== 1)  begin nfail++; $display("FAIL drop_pulses got %0d want 1", rc4 - rc0); end
    ncmp++; if (ws4 !== 16'd10)   begin nfail++; $display("FAIL drop_words got %0d want 10", ws4); end
    ncmp++; if (8'(wp4 - rp4) !== 8'd2) begin nfail++; $display("FAIL drop_retained got %0d want 2", 8'(wp4 - rp4)); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    int t0, n = 0;
    enable4 = 1'b1;
    @(negedge clk);
    while (ser4 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ncmp++; if (ser4 !== 1'b1)  begin nfail++; $display("FAIL midrst_ser got %b want 1", ser4); end
    ncmp++; if (busy4 !== 1'b0) begin nfail++; $display("FAIL midrst_busy got %b want 0", busy4); end
    ncmp++; if (ws4 !== 16'd0)  begin nfail++; $display("FAIL midrst_words got %0d want 0", ws4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    recv(0, w, t0);
    ncmp++; if (w !== 16'h0012) begin nfail++; $display("FAIL midrst_next got %h want 0012", w); end
    repeat (5) @(negedge clk);
    ncmp++; if (ws4 !== 16'd1)  begin nfail++; $display("FAIL midrst_words_after got %0d want 1", ws4); end
    enable4 = 1'b0;
  endtask

  task automatic test_bit_period_one;
    logic [15:0] w;
    logic [15:0] exp [3];
    int t0, tp, pc, rc0;
    exp[0] = 16'h1234; exp[1] = 16'hFFFF; exp[2] = 16'h0001;
    enable1 = 1'b1;
    @(negedge clk);
    rc0 = rc1;
    pc  = cyc;
    for (int i = 0; i < 3; i++) push1(exp[i]);
    for (int i = 0; i < 3; i++) begin
      recv(1, w, t0);
      ncmp++; if (w !== exp[i]) begin nfail++; $display("FAIL bp1_word%0d got %h want %h", i, w, exp[i]); end
      if (i == 0) begin
        ncmp++; if (t0 - pc !== 4) begin nfail++; $display("FAIL bp1_latency got %0d want 4", t0 - pc); end
      end else begin
        ncmp++; if (t0 - tp !== 20) begin nfail++; $display("FAIL bp1_gap%0d got %0d want 20", i, t0 - tp); end
      end
      tp = t0;
    end
    repeat (10) @(negedge clk);
    ncmp++; if (ws1 !== 16'd3)   begin nfail++; $display("FAIL bp1_words got %0d want 3", ws1); end
    ncmp++; if (rc1 - rc0 !== 3) begin nfail++; $display("FAIL bp1_pulses got %0d want 3", rc1 - rc0); end
    ncmp++; if (bad1 !== 0)      begin nfail++; $display("FAIL bp1_empty_pop got %0d want 0", bad1); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    test_bit_period_one;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
